// File: rtl/inst_fetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// inst_fetch_queue_pkg
//   Definitions shared by the instruction fetch queue and its storage:
//   - fetch_state_e : memory-side FSM state encoding (IDLE / WAIT / DISCARD)
//   - ZeroWord      : 32-bit all-zero word for idle instruction outputs
//   - STALL_PC/ID   : bit positions in the pipeline stall vector
//                     (bit 0 = hold the PC stage, bit 1 = decode not accepting)
// ----------------------------------------------------------------------------
package inst_fetch_queue_pkg;

   typedef enum logic [1:0] {
      FSM_IDLE    = 2'd0,
      FSM_WAIT    = 2'd1,
      FSM_DISCARD = 2'd2
   } fetch_state_e;

   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   localparam int STALL_PC = 0;
   localparam int STALL_ID = 1;
   localparam int STALL_W  = 2;

endpackage

// File: rtl/ifq_fifo.sv
// ----------------------------------------------------------------------------
// ifq_fifo
//   Circular buffer of DEPTH entries, each WIDTH bits wide.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     push_i, wdata_i : write wdata_i at the tail
//     pop_i           : advance the head (ignored when empty)
//     flush_i         : discard every entry; overrides push and pop
//     rdata_o         : head entry (undefined content when empty)
//     full_o, empty_o : occupancy flags
//     count_o         : number of valid entries (log2(DEPTH)+1 bits)
//   A push while full is accepted only when a pop happens in the same cycle.
// ----------------------------------------------------------------------------
module ifq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign full_o    = (count_q == CNT_W'(DEPTH));
   assign empty_o   = (count_q == {CNT_W{1'b0}});
   assign count_o   = count_q;
   assign rdata_o   = mem_q[rd_ptr_q];
   assign do_pop_s  = pop_i && !empty_o;
   assign do_push_s = push_i && (!full_o || do_pop_s);

   // Next-state for pointers and occupancy; flush wins over push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (do_push_s && !flush_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/inst_fetch_queue.sv
// ----------------------------------------------------------------------------
// inst_fetch_queue
//   Decouples the PC stage from instruction memory. A small FSM issues one
//   read at a time, and returned {pc, instruction} pairs are buffered in an
//   ifq_fifo until the decode stage accepts them.
//   Ports:
//     clk, rst                : clock, synchronous active-high reset
//     pc_i, pc_ce_i           : fetch address and PC-stage enable
//     stallreq_o              : hold the PC stage (low only on an issue cycle)
//     mem_req_o, mem_addr_o   : instruction memory read request / address
//     mem_ack_i, mem_data_i   : memory response
//     flush_i                 : redirect; drops queued and in-flight work
//     id_stall_i              : decode stage not accepting
//     id_valid_o, id_pc_o,
//     id_inst_o               : head instruction presented to decode
//   Build option: define IFQ_BYPASS_EN to forward an ack straight to the
//   decode outputs when the queue is empty and decode is accepting.
// ----------------------------------------------------------------------------
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              pc_ce_i,
   output logic              stallreq_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ack_i,
   input  logic [31:0]       mem_data_i,
   input  logic              flush_i,
   input  logic              id_stall_i,
   output logic              id_valid_o,
   output logic [ADDR_W-1:0] id_pc_o,
   output logic [31:0]       id_inst_o
);

   localparam int CNT_W   = $clog2(DEPTH) + 1;
   localparam int ENTRY_W = ADDR_W + 32;

   fetch_state_e        state_q;
   logic                mem_req_q;
   logic [ADDR_W-1:0]   mem_addr_q;   // doubles as the latched fetch PC

   logic [STALL_W-1:0]  stall_s;
   logic                issue_s;
   logic                ack_take_s;
   logic                bypass_s;
   logic                fifo_push_s;
   logic                fifo_pop_s;
   logic [ENTRY_W-1:0]  fifo_rdata_s;
   logic                full_s;
   logic                empty_s;
   logic [CNT_W-1:0]    count_s;

   // A fetch is issued only from IDLE, with the PC stage enabled, no redirect
   // and at least one free entry; the PC stage advances only on that cycle.
   assign issue_s = !rst && (state_q == FSM_IDLE) && pc_ce_i && !flush_i
                    && (count_s != CNT_W'(DEPTH));

   // Ack data is kept only in WAIT and only when no redirect is arriving.
   assign ack_take_s = !rst && (state_q == FSM_WAIT) && mem_ack_i && !flush_i;

   assign stall_s[STALL_PC] = !issue_s;
   assign stall_s[STALL_ID] = id_stall_i;

`ifdef IFQ_BYPASS_EN
   assign bypass_s = ack_take_s && empty_s && !stall_s[STALL_ID];
`else
   assign bypass_s = 1'b0;
`endif

   assign fifo_pop_s  = !empty_s && !stall_s[STALL_ID];
   assign fifo_push_s = ack_take_s && !bypass_s;

   assign stallreq_o = stall_s[STALL_PC];
   assign mem_req_o  = mem_req_q;
   assign mem_addr_o = mem_addr_q;

   ifq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push_s),
      .pop_i   (fifo_pop_s),
      .flush_i (flush_i),
      .wdata_i ({mem_addr_q, mem_data_i}),
      .rdata_o (fifo_rdata_s),
      .full_o  (full_s),
      .empty_o (empty_s),
      .count_o (count_s)
   );

   // Memory-side FSM; the request stays high through DISCARD until the
   // abandoned read is acknowledged so the memory handshake always completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FSM_IDLE;
         mem_req_q  <= 1'b0;
         mem_addr_q <= {ADDR_W{1'b0}};
      end else begin
         case (state_q)
            FSM_IDLE: begin
               if (issue_s) begin
                  state_q    <= FSM_WAIT;
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= pc_i;
               end
            end
            FSM_WAIT: begin
               if (mem_ack_i) begin
                  state_q   <= FSM_IDLE;
                  mem_req_q <= 1'b0;
               end else if (flush_i) begin
                  state_q <= FSM_DISCARD;
               end
            end
            FSM_DISCARD: begin
               if (mem_ack_i) begin
                  state_q   <= FSM_IDLE;
                  mem_req_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= FSM_IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   // Decode-side outputs: forwarded ack, else queue head, else zeros.
   always_comb begin
      id_valid_o = 1'b0;
      id_pc_o    = {ADDR_W{1'b0}};
      id_inst_o  = ZeroWord;
      if (bypass_s) begin
         id_valid_o = 1'b1;
         id_pc_o    = mem_addr_q;
         id_inst_o  = mem_data_i;
      end else if (!empty_s) begin
         id_valid_o = 1'b1;
         id_pc_o    = fifo_rdata_s[ENTRY_W-1:32];
         id_inst_o  = fifo_rdata_s[31:0];
      end else begin
         id_valid_o = 1'b0;
         id_pc_o    = {ADDR_W{1'b0}};
         id_inst_o  = ZeroWord;
      end
   end

endmodule
